// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix geometry, scan-row encoding and a one-hot test
// used by the scanner and the downstream encoder.
package keypad_pkg;

    localparam int unsigned KP_ROWS  = 4;
    localparam int unsigned KP_COLS  = 4;
    localparam int unsigned KP_KEYS  = KP_ROWS * KP_COLS;
    localparam int unsigned KP_ROW_W = $clog2(KP_ROWS);

    typedef enum logic [KP_ROW_W-1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        ROW3 = 2'd3
    } kp_row_e;

    // True when exactly one key bit is set.
    function automatic logic kp_is_onehot(input logic [KP_KEYS-1:0] v);
        return (v != '0) && ((v & (v - KP_KEYS'(1))) == '0);
    endfunction

endpackage

// File: rtl/kp_debounce.sv
// Whole-matrix debouncer: assembles a snapshot row by row and only publishes it
// once it has repeated for DEBOUNCE_SCANS consecutive scans.
module kp_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_sample,
    input  logic                i_scan_end,
    input  logic [KP_ROW_W-1:0] i_row,
    input  logic [KP_COLS-1:0]  i_cols,
    output logic [KP_KEYS-1:0]  o_stable
);

    localparam int unsigned         CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic [KP_KEYS-1:0] r_snapshot;
    logic [KP_KEYS-1:0] r_prev;
    logic [KP_KEYS-1:0] r_stable;
    logic [CNT_W-1:0]   r_deb_cnt;
    logic [KP_KEYS-1:0] w_snap_full;

    // Snapshot with the current row's columns merged in, so the scan end sees row 3.
    always_comb begin
        w_snap_full = r_snapshot;
        w_snap_full[{i_row, 2'b00} +: KP_COLS] = i_cols;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snapshot <= '0;
            r_prev     <= '0;
            r_stable   <= '0;
            r_deb_cnt  <= '0;
        end else begin
            if (i_sample) begin
                r_snapshot <= w_snap_full;
            end
            if (i_scan_end) begin
                if (w_snap_full == r_prev) begin
                    if (r_deb_cnt != CNT_MAX) begin
                        r_deb_cnt <= r_deb_cnt + CNT_W'(1);
                    end
                end else begin
                    r_deb_cnt <= '0;
                    r_prev    <= w_snap_full;
                end
            end
            if (r_deb_cnt == CNT_MAX) begin
                r_stable <= r_prev;
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: walks the rows, synchronises the columns, debounces full
// snapshots and presents a single-key one-hot vector with press/hold flags.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KP_COLS-1:0] col_in,
    output logic [KP_ROWS-1:0] row_out,
    output logic [KP_KEYS-1:0] onehot,
    output logic               key_valid,
    output logic               key_held
);

    localparam int unsigned          DWELL_W    = $clog2(SCAN_DIV);
    localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(SCAN_DIV - 1);

    logic [KP_COLS-1:0] r_col_meta;
    logic [KP_COLS-1:0] r_col_sync;
    logic [DWELL_W-1:0] r_dwell;
    kp_row_e            r_state;
    kp_row_e            w_state_nxt;
    logic [KP_ROWS-1:0] r_row_out;
    logic [KP_ROWS-1:0] w_row_out_nxt;
    logic               w_last;
    logic               w_sample;
    logic               w_scan_end;
    logic [KP_KEYS-1:0] w_stable;
    logic [KP_KEYS-1:0] w_onehot_nxt;
    logic [KP_KEYS-1:0] r_onehot;
    logic               r_key_valid;
    logic               r_key_held;

    assign w_last = (r_dwell == DWELL_LAST);

    // Column synchroniser; pins are asynchronous and active-low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_meta <= '1;
            r_col_sync <= '1;
        end else begin
            r_col_meta <= col_in;
            r_col_sync <= r_col_meta;
        end
    end

    // Scan state register with its dwell counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ROW0;
            r_dwell   <= '0;
            r_row_out <= 4'b1110;
        end else begin
            r_state   <= w_state_nxt;
            r_dwell   <= w_last ? '0 : r_dwell + DWELL_W'(1);
            r_row_out <= w_row_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_last) begin
            case (r_state)
                ROW0:    w_state_nxt = ROW1;
                ROW1:    w_state_nxt = ROW2;
                ROW2:    w_state_nxt = ROW3;
                ROW3:    w_state_nxt = ROW0;
                default: w_state_nxt = ROW0;
            endcase
        end
    end

    // Columns are sampled on the last dwell cycle so the sync chain has settled.
    always_comb begin
        w_row_out_nxt = ~(4'b0001 << w_state_nxt);
        w_sample      = w_last;
        w_scan_end    = w_last && (r_state == ROW3);
    end

    kp_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .i_sample   (w_sample),
        .i_scan_end (w_scan_end),
        .i_row      (r_state),
        .i_cols     (~r_col_sync),
        .o_stable   (w_stable)
    );

    // Multi-key chords are suppressed; a new press only counts coming from idle.
    assign w_onehot_nxt = kp_is_onehot(w_stable) ? w_stable : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_onehot    <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_onehot    <= w_onehot_nxt;
            r_key_valid <= (r_onehot == '0) && (w_onehot_nxt != '0);
            r_key_held  <= (w_onehot_nxt != '0);
        end
    end

    assign row_out   = r_row_out;
    assign onehot    = r_onehot;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 switch matrix
// (SCAN_DIV=4, DEBOUNCE_SCANS=2, one full scan = 16 clks).
module tb_keypad_scan_ctrl;

    localparam int LAT = 67;

    logic        clk;
    logic        rst;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] onehot;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;
    logic [3:0]  row_seq [4];

    int n_vec;
    int n_err;
    int pulse_cnt;
    int hi_cnt;
    int pc0;
    int hc0;

    keypad_scan_ctrl #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_out   (row_out),
        .onehot    (onehot),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch matrix: a pressed key shorts its column to its row when that row is low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_out[r]) col_in = col_in & ~pressed[r*4 +: 4];
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            pulse_cnt += int'(key_valid);
            hi_cnt    += (onehot != 16'h0) ? 1 : 0;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_onehot(input string tag, input logic [15:0] exp, input int bound);
        int k = 0;
        while (onehot !== exp && k < bound) begin
            tick(1);
            k++;
        end
        check(tag, onehot, exp);
    endtask

    initial begin
        n_vec = 0; n_err = 0; pulse_cnt = 0; hi_cnt = 0;
        row_seq[0] = 4'b1110; row_seq[1] = 4'b1101;
        row_seq[2] = 4'b1011; row_seq[3] = 4'b0111;
        pressed = 16'h0;
        rst = 1'b1;
        tick(3);
        check("rst_row",   16'(row_out),   16'h000E);
        check("rst_onehot", onehot,        16'h0000);
        check("rst_valid", 16'(key_valid), 16'h0000);
        check("rst_held",  16'(key_held),  16'h0000);

        // Row walk: 3 scans, each row value for exactly 4 clks, no key.
        rst = 1'b0;
        for (int i = 0; i < 48; i++) begin
            check("row_walk", 16'(row_out), 16'(row_seq[(i / 4) % 4]));
            tick(1);
        end
        check("walk_onehot", onehot, 16'h0000);
        check("walk_hi", 16'(hi_cnt), 16'h0000);

        // Asynchronous reset in the middle of ROW2.
        tick(9);
        check("mid_row2", 16'(row_out), 16'h000B);
        rst = 1'b1;
        #1;
        check("async_row",    16'(row_out),   16'h000E);
        check("async_onehot", onehot,         16'h0000);
        check("async_valid",  16'(key_valid), 16'h0000);
        tick(1);
        rst = 1'b0;
        tick(20);

        // Single press row1/col2, held for 10 scans, then released.
        pc0 = pulse_cnt;
        pressed = 16'h0040;
        wait_onehot("press_0040", 16'h0040, LAT);
        check("press_valid", 16'(key_valid), 16'h0001);
        check("press_held",  16'(key_held),  16'h0001);
        tick(1);
        check("valid_1clk", 16'(key_valid), 16'h0000);
        tick(100);
        check("hold_onehot", onehot, 16'h0040);
        check("hold_held", 16'(key_held), 16'h0001);
        check("hold_pulses", 16'(pulse_cnt - pc0), 16'h0001);
        pressed = 16'h0;
        wait_onehot("release_0040", 16'h0000, LAT);
        check("release_held", 16'(key_held), 16'h0000);
        tick(20);

        // Bounce on row1/col2 toggling every 5 clks for 3 scans, then held.
        pc0 = pulse_cnt;
        for (int i = 0; i < 48; i++) begin
            if (i % 5 == 0) pressed[6] = ~pressed[6];
            tick(1);
        end
        check("bounce_pulses", 16'(pulse_cnt - pc0), 16'h0000);
        check("bounce_onehot", onehot, 16'h0000);
        pressed = 16'h0040;
        wait_onehot("settle_0040", 16'h0040, LAT);
        check("settle_valid", 16'(key_valid), 16'h0001);
        tick(16);
        check("settle_pulses", 16'(pulse_cnt - pc0), 16'h0001);
        pressed = 16'h0;
        wait_onehot("settle_release", 16'h0000, LAT);
        tick(20);

        // Two keys together are rejected.
        pc0 = pulse_cnt;
        hc0 = hi_cnt;
        pressed = 16'h8001;
        tick(96);
        check("multi_onehot", onehot, 16'h0000);
        check("multi_hi", 16'(hi_cnt - hc0), 16'h0000);
        check("multi_pulses", 16'(pulse_cnt - pc0), 16'h0000);
        pressed = 16'h0;
        tick(64);

        // Roll-over: 0008 -> both -> 8000 must pass through 0.
        pc0 = pulse_cnt;
        pressed = 16'h0008;
        wait_onehot("roll_0008", 16'h0008, LAT);
        check("roll_valid1", 16'(key_valid), 16'h0001);
        pressed = 16'h8008;
        wait_onehot("roll_zero", 16'h0000, LAT);
        check("roll_zero_held", 16'(key_held), 16'h0000);
        pressed = 16'h8000;
        wait_onehot("roll_8000", 16'h8000, LAT);
        check("roll_valid2", 16'(key_valid), 16'h0001);
        tick(5);
        check("roll_pulses", 16'(pulse_cnt - pc0), 16'h0002);

        // Reset with a key held: output clears at once, returns only after debounce.
        rst = 1'b1;
        #1;
        check("krst_onehot", onehot,        16'h0000);
        check("krst_held",   16'(key_held), 16'h0000);
        check("krst_row",    16'(row_out),  16'h000E);
        tick(1);
        rst = 1'b0;
        tick(40);
        check("krst_early", onehot, 16'h0000);
        wait_onehot("krst_back", 16'h8000, LAT);
        check("krst_valid", 16'(key_valid), 16'h0001);
        pressed = 16'h0;
        wait_onehot("krst_release", 16'h0000, LAT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
